// File: rtl/sequence_checker.sv
// Stream sink that checks an incrementing word sequence per frame
// and emits one {error_count, first_bad} summary word per frame.
module sequence_checker #(
  parameter int          WIDTH = 32,
  parameter int          COUNT = 10,
  parameter logic [31:0] START = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_z,
  input  logic             input_z_stb,
  output logic             input_z_ack,
  output logic [31:0]      output_result,
  output logic             output_result_stb,
  input  logic             output_result_ack,
  output logic             mismatch
);

  typedef enum logic {
    RECEIVE,
    REPORT
  } state_e;

  localparam logic [15:0]      LAST    = 16'(COUNT - 1);
  localparam logic [15:0]      NONE    = 16'hFFFF;
  localparam logic [WIDTH-1:0] START_W = START[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [15:0]      word_index_q, word_index_d;
  logic [15:0]      error_count_q, error_count_d;
  logic [15:0]      first_bad_q, first_bad_d;
  logic             ack_q, ack_d;
  logic             res_stb_q, res_stb_d;
  logic [31:0]      result_q, result_d;
  logic             mismatch_q, mismatch_d;

  logic        in_xfer;
  logic        out_xfer;
  logic        last_xfer;
  logic        bad;
  logic [15:0] err_nx;
  logic [15:0] fb_nx;

  assign in_xfer   = (state_q == RECEIVE) && ack_q && input_z_stb;
  assign out_xfer  = (state_q == REPORT) && res_stb_q
                     && output_result_ack;
  assign last_xfer = in_xfer && (word_index_q == LAST);
  assign bad       = (input_z != expected_q);

  // Statistics including the word on the current edge
  always_comb begin
    err_nx = error_count_q;
    fb_nx  = first_bad_q;
    if (bad && (error_count_q != 16'hFFFF)) begin
      err_nx = error_count_q + 16'd1;
    end
    if (bad && (first_bad_q == NONE)) begin
      fb_nx = word_index_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RECEIVE;
      expected_q    <= START_W;
      word_index_q  <= 16'd0;
      error_count_q <= 16'd0;
      first_bad_q   <= NONE;
      ack_q         <= 1'b0;
      res_stb_q     <= 1'b0;
      result_q      <= 32'd0;
      mismatch_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      word_index_q  <= word_index_d;
      error_count_q <= error_count_d;
      first_bad_q   <= first_bad_d;
      ack_q         <= ack_d;
      res_stb_q     <= res_stb_d;
      result_q      <= result_d;
      mismatch_q    <= mismatch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RECEIVE: if (last_xfer) state_d = REPORT;
      REPORT:  if (out_xfer)  state_d = RECEIVE;
    endcase
  end

  always_comb begin
    expected_d    = expected_q;
    word_index_d  = word_index_q;
    error_count_d = error_count_q;
    first_bad_d   = first_bad_q;
    ack_d         = 1'b0;
    res_stb_d     = res_stb_q;
    result_d      = result_q;
    mismatch_d    = 1'b0;
    unique case (state_q)
      RECEIVE: begin
        ack_d = !last_xfer;
        if (in_xfer) begin
          mismatch_d    = bad;
          error_count_d = err_nx;
          first_bad_d   = fb_nx;
          expected_d    = expected_q + WIDTH'(1);
          word_index_d  = word_index_q + 16'd1;
        end
        if (last_xfer) begin
          result_d  = {err_nx, fb_nx};
          res_stb_d = 1'b1;
        end
      end
      REPORT: begin
        if (out_xfer) begin
          ack_d         = 1'b1;
          res_stb_d     = 1'b0;
          expected_d    = START_W;
          word_index_d  = 16'd0;
          error_count_d = 16'd0;
          first_bad_d   = NONE;
        end
      end
    endcase
  end

  assign input_z_ack       = ack_q;
  assign output_result     = result_q;
  assign output_result_stb = res_stb_q;
  assign mismatch          = mismatch_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: default frame and an
// 8-bit wrapping instance with a short frame.
module tb_sequence_checker;

  logic        clk;
  logic        rst;

  logic [31:0] in_z;
  logic        in_stb;
  logic        in_ack;
  logic [31:0] res;
  logic        res_stb;
  logic        res_ack;
  logic        mm;

  logic [7:0]  w_z;
  logic        w_stb;
  logic        w_ack;
  logic [31:0] w_res;
  logic        w_res_stb;
  logic        w_res_ack;
  logic        w_mm;

  int total;
  int passed;
  int mm_cnt;
  int base;

  sequence_checker u_dut (
    .clk               (clk),
    .rst               (rst),
    .input_z           (in_z),
    .input_z_stb       (in_stb),
    .input_z_ack       (in_ack),
    .output_result     (res),
    .output_result_stb (res_stb),
    .output_result_ack (res_ack),
    .mismatch          (mm)
  );

  sequence_checker #(
    .WIDTH (8),
    .COUNT (4),
    .START (32'd254)
  ) u_wrap (
    .clk               (clk),
    .rst               (rst),
    .input_z           (w_z),
    .input_z_stb       (w_stb),
    .input_z_ack       (w_ack),
    .output_result     (w_res),
    .output_result_stb (w_res_stb),
    .output_result_ack (w_res_ack),
    .mismatch          (w_mm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial mm_cnt = 0;
  always @(negedge clk) begin
    if (mm === 1'b1) mm_cnt = mm_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] v);
    int n;
    n = 0;
    in_z   = v;
    in_stb = 1'b1;
    while (!in_ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk); #1;
    in_stb = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] v);
    int n;
    n = 0;
    w_z   = v;
    w_stb = 1'b1;
    while (!w_ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wsend_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk); #1;
    w_stb = 1'b0;
  endtask

  initial begin
    logic [31:0] vals [10];
    total     = 0;
    passed    = 0;
    rst       = 1'b0;
    in_z      = '0;
    in_stb    = 1'b0;
    res_ack   = 1'b0;
    w_z       = '0;
    w_stb     = 1'b0;
    w_res_ack = 1'b1;

    #1 rst = 1'b1;
    #2;
    chk("rst_ack", 32'(in_ack), 32'd0);
    chk("rst_stb", 32'(res_stb), 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_mm", 32'(mm), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("ack_rise", 32'(in_ack), 32'd1);

    // clean frame
    res_ack = 1'b1;
    base = mm_cnt;
    for (int i = 1; i <= 10; i++) send(32'(i));
    chk("t1_stb", 32'(res_stb), 32'd1);
    chk("t1_res", res, 32'h0000FFFF);
    chk("t1_ack", 32'(in_ack), 32'd0);
    chk("t1_mm", 32'(mm_cnt - base), 32'd0);
    @(posedge clk); #1;
    chk("t1_drain_stb", 32'(res_stb), 32'd0);
    chk("t1_drain_ack", 32'(in_ack), 32'd1);

    // one bad word at index 3
    vals = '{1, 2, 3, 7, 5, 6, 7, 8, 9, 10};
    base = mm_cnt;
    for (int i = 0; i < 10; i++) begin
      send(vals[i]);
      if (i == 2) chk("t2_mm_pre", 32'(mm), 32'd0);
      if (i == 3) chk("t2_mm_hit", 32'(mm), 32'd1);
      if (i == 4) chk("t2_mm_clr", 32'(mm), 32'd0);
    end
    chk("t2_res", res, 32'h00010003);
    chk("t2_mm_cnt", 32'(mm_cnt - base), 32'd1);
    @(posedge clk); #1;

    // result back-pressure with a pending input word
    res_ack = 1'b0;
    for (int i = 1; i <= 10; i++) send(32'(i));
    in_z   = 32'd1;
    in_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t3_hold_ack", 32'(in_ack), 32'd0);
      chk("t3_hold_stb", 32'(res_stb), 32'd1);
      chk("t3_hold_res", res, 32'h0000FFFF);
    end
    res_ack = 1'b1;
    @(posedge clk); #1;
    chk("t3_rel_stb", 32'(res_stb), 32'd0);
    chk("t3_rel_ack", 32'(in_ack), 32'd1);
    @(posedge clk); #1;
    in_stb = 1'b0;
    chk("t3_w0_mm", 32'(mm), 32'd0);
    for (int i = 2; i <= 10; i++) send(32'(i));
    chk("t3_res", res, 32'h0000FFFF);
    chk("t3_stb", 32'(res_stb), 32'd1);
    @(posedge clk); #1;

    // 8-bit wrap instance
    send_w(8'd254);
    send_w(8'd255);
    send_w(8'd0);
    send_w(8'd1);
    chk("t4_stb", 32'(w_res_stb), 32'd1);
    chk("t4_res", w_res, 32'h0000FFFF);
    chk("t4_mm", 32'(w_mm), 32'd0);

    // async reset mid-frame
    send(32'd1);
    send(32'd5);
    send(32'd6);
    chk("t5_mm", 32'(mm), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t5_ack", 32'(in_ack), 32'd0);
    chk("t5_mm_rst", 32'(mm), 32'd0);
    chk("t5_stb", 32'(res_stb), 32'd0);
    chk("t5_res", res, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_ack_rise", 32'(in_ack), 32'd1);
    for (int i = 1; i <= 10; i++) send(32'(i));
    chk("t5_res_after", res, 32'h0000FFFF);
    @(posedge clk); #1;

    // stb gaps, bad word 0
    vals = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    base = mm_cnt;
    for (int i = 0; i < 10; i++) begin
      send(vals[i]);
      if (i == 0) chk("t6_mm_hit", 32'(mm), 32'd1);
      if (i == 9) begin
        chk("t6_stb", 32'(res_stb), 32'd1);
        chk("t6_res", res, 32'h00010000);
      end else begin
        for (int g = 0; g < 3; g++) begin
          @(posedge clk); #1;
        end
        if (i == 0) begin
          chk("t6_mm_gap", 32'(mm), 32'd0);
          chk("t6_stb_gap", 32'(res_stb), 32'd0);
        end
      end
    end
    chk("t6_mm_cnt", 32'(mm_cnt - base), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
